// File: rtl/oe_lane_sequencer_pkg.sv
// Shared encodings for the odd/even lane sequencer: request modes, element
// widths, FSM states and small decode helpers.
package oe_lane_sequencer_pkg;

  localparam logic [1:0] MODE_EVEN     = 2'b00;
  localparam logic [1:0] MODE_ODD      = 2'b01;
  localparam logic [1:0] MODE_EVEN_ODD = 2'b10;
  localparam logic [1:0] MODE_ODD_EVEN = 2'b11;

  localparam logic [1:0] WW_BYTE  = 2'b00;
  localparam logic [1:0] WW_HALF  = 2'b01;
  localparam logic [1:0] WW_WORD  = 2'b10;
  localparam logic [1:0] WW_DWORD = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_BEAT1 = 2'b01;
  localparam logic [1:0] ST_BEAT2 = 2'b10;

  typedef struct packed {
    logic odd;
    logic last;
    logic err;
  } beat_flags_t;

  // An element width is usable only if at least one even/odd pair fits the operand.
  function automatic logic ww_legal(input logic [1:0] ww, input int unsigned dw);
    return ((32'd16 << ww) <= dw);
  endfunction

  function automatic logic mode_two_beat(input logic [1:0] mode);
    return (mode == MODE_EVEN_ODD) || (mode == MODE_ODD_EVEN);
  endfunction

  function automatic logic mode_first_odd(input logic [1:0] mode);
    return (mode == MODE_ODD) || (mode == MODE_ODD_EVEN);
  endfunction

endpackage

// File: rtl/oe_lane_sequencer_extract.sv
// Combinational lane extractor: packs the even or odd elements of a
// big-endian operand into a half-width result, zero for unusable widths.
module oe_lane_extract
  import oe_lane_sequencer_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [0:DW-1]   op,
  input  logic [1:0]      ww,
  input  logic            odd,
  output logic [0:DW/2-1] res
);

  logic [0:DW/2-1] by_width [4];

  for (genvar w = 0; w < 4; w++) begin : g_w
    localparam int E = 8 << w;
    if (2 * E <= DW) begin : g_legal
      for (genvar j = 0; j < DW / (2 * E); j++) begin : g_lane
        assign by_width[w][j*E +: E] = odd ? op[(2*j+1)*E +: E] : op[(2*j)*E +: E];
      end
    end else begin : g_illegal
      assign by_width[w] = '0;
    end
  end

  // Select the packing that matches the requested element width.
  always_comb begin
    res = '0;
    case (ww)
      WW_BYTE:  res = by_width[0];
      WW_HALF:  res = by_width[1];
      WW_WORD:  res = by_width[2];
      WW_DWORD: res = by_width[3];
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/oe_lane_sequencer.sv
// Odd/even lane sequencer: accepts an operand pair and emits one or two
// registered beats of packed even and/or odd lanes under ready/valid flow.
module oe_lane_sequencer
  import oe_lane_sequencer_pkg::*;
#(
  parameter int DW    = 64,
  parameter int W_OUT = DW / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:DW-1]    op1,
  input  logic [0:DW-1]    op2,
  input  logic [1:0]       ww,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:W_OUT-1] opA,
  output logic [0:W_OUT-1] opB,
  output logic             out_odd,
  output logic             out_last,
  output logic             out_err
);

  logic [1:0]       state_q, state_d;
  logic [0:DW-1]    op1_q, op2_q;
  logic [1:0]       ww_q, mode_q;
  logic             out_valid_q, out_valid_d;
  logic [0:W_OUT-1] opa_q, opa_d, opb_q, opb_d;
  beat_flags_t      flags_q, flags_d;

  logic             accept, consume;
  logic             legal_in, stored_two_beat;
  logic             load_first, load_second, go_idle;
  logic [0:DW-1]    ext_op1, ext_op2;
  logic [1:0]       ext_ww;
  logic             ext_odd;
  logic [0:W_OUT-1] ext_a, ext_b;

  // A new request can slot in as soon as the final beat of the current one drains.
  assign in_ready = (state_q == ST_IDLE) | (out_valid_q & out_ready & flags_q.last);
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid_q & out_ready;

  assign legal_in        = ww_legal(ww, DW);
  assign stored_two_beat = ww_legal(ww_q, DW) & mode_two_beat(mode_q);

  // First beats come straight from the inputs; second beats from the captured request.
  always_comb begin
    ext_op1 = op1_q;
    ext_op2 = op2_q;
    ext_ww  = ww_q;
    ext_odd = ~mode_first_odd(mode_q);
    if (accept) begin
      ext_op1 = op1;
      ext_op2 = op2;
      ext_ww  = ww;
      ext_odd = mode_first_odd(mode);
    end else begin
      ext_op1 = op1_q;
      ext_op2 = op2_q;
      ext_ww  = ww_q;
      ext_odd = ~mode_first_odd(mode_q);
    end
  end

  oe_lane_extract #(.DW(DW)) u_extract_op1 (
    .op  (ext_op1),
    .ww  (ext_ww),
    .odd (ext_odd),
    .res (ext_a)
  );

  oe_lane_extract #(.DW(DW)) u_extract_op2 (
    .op  (ext_op2),
    .ww  (ext_ww),
    .odd (ext_odd),
    .res (ext_b)
  );

  // Sequencing decisions: which beat (if any) is loaded into the output registers.
  always_comb begin
    state_d     = state_q;
    load_first  = 1'b0;
    load_second = 1'b0;
    go_idle     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_BEAT1;
          load_first = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BEAT1: begin
        if (consume && stored_two_beat) begin
          state_d     = ST_BEAT2;
          load_second = 1'b1;
        end else if (consume && accept) begin
          state_d    = ST_BEAT1;
          load_first = 1'b1;
        end else if (consume) begin
          state_d = ST_IDLE;
          go_idle = 1'b1;
        end else begin
          state_d = ST_BEAT1;
        end
      end
      ST_BEAT2: begin
        if (consume && accept) begin
          state_d    = ST_BEAT1;
          load_first = 1'b1;
        end else if (consume) begin
          state_d = ST_IDLE;
          go_idle = 1'b1;
        end else begin
          state_d = ST_BEAT2;
        end
      end
      default: begin
        state_d = ST_IDLE;
        go_idle = 1'b1;
      end
    endcase
  end

  // Output beat contents; untouched while the current beat is back-pressured.
  always_comb begin
    out_valid_d = out_valid_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    flags_d     = flags_q;
    if (load_first) begin
      out_valid_d  = 1'b1;
      opa_d        = ext_a;
      opb_d        = ext_b;
      flags_d.odd  = legal_in & mode_first_odd(mode);
      flags_d.last = ~legal_in | ~mode_two_beat(mode);
      flags_d.err  = ~legal_in;
    end else if (load_second) begin
      out_valid_d  = 1'b1;
      opa_d        = ext_a;
      opb_d        = ext_b;
      flags_d.odd  = ~mode_first_odd(mode_q);
      flags_d.last = 1'b1;
      flags_d.err  = 1'b0;
    end else if (go_idle) begin
      out_valid_d = 1'b0;
      opa_d       = '0;
      opb_d       = '0;
      flags_d     = '0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State, output and captured-request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      flags_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      ww_q        <= 2'b00;
      mode_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      flags_q     <= flags_d;
      if (load_first) begin
        op1_q  <= op1;
        op2_q  <= op2;
        ww_q   <= ww;
        mode_q <= mode;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign opA       = opa_q;
  assign opB       = opb_q;
  assign out_odd   = flags_q.odd;
  assign out_last  = flags_q.last;
  assign out_err   = flags_q.err;

endmodule

// File: tb/tb_oe_lane_sequencer.sv
// Self-checking bench for oe_lane_sequencer: directed scenarios plus a
// randomized run against a queue-based beat model.
module tb_oe_lane_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] op1 = 64'd0, op2 = 64'd0;
  logic [1:0]  ww = 2'd0, mode = 2'd0;
  logic        in_ready, out_valid, out_odd, out_last, out_err;
  logic [31:0] opA, opB;

  logic         w_in_valid = 1'b0, w_out_ready = 1'b0;
  logic [127:0] w_op1 = 128'd0, w_op2 = 128'd0;
  logic [1:0]   w_ww = 2'd0, w_mode = 2'd0;
  logic         w_in_ready, w_out_valid, w_out_odd, w_out_last, w_out_err;
  logic [63:0]  w_opA, w_opB;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        odd;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];

  oe_lane_sequencer #(.DW(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .ww(ww), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .opA(opA), .opB(opB),
    .out_odd(out_odd), .out_last(out_last), .out_err(out_err)
  );

  oe_lane_sequencer #(.DW(128)) dut_w (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .op1(w_op1), .op2(w_op2), .ww(w_ww), .mode(w_mode),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .opA(w_opA), .opB(w_opB),
    .out_odd(w_out_odd), .out_last(w_out_last), .out_err(w_out_err)
  );

  // Element k of width e counts from the most significant end of the operand.
  function automatic logic [31:0] ref_lanes(input logic [63:0] op, input int e, input int p);
    logic [63:0] acc;
    logic [63:0] mask;
    acc  = 64'd0;
    mask = (64'd1 << e) - 64'd1;
    for (int j = 0; j < 64 / (2 * e); j++) begin
      acc = (acc << e) | ((op >> (64 - (2 * j + p + 1) * e)) & mask);
    end
    return acc[31:0];
  endfunction

  task automatic push_request(input logic [63:0] a, input logic [63:0] b,
                              input logic [1:0] w, input logic [1:0] m);
    int    e;
    int    order[$];
    beat_t bt;
    e = 8 << w;
    if (2 * e > 64) begin
      bt = '{a: 32'd0, b: 32'd0, odd: 1'b0, last: 1'b1, err: 1'b1};
      exp_q.push_back(bt);
    end else begin
      case (m)
        2'd0:    order = '{0};
        2'd1:    order = '{1};
        2'd2:    order = '{0, 1};
        default: order = '{1, 0};
      endcase
      foreach (order[i]) begin
        bt.a    = ref_lanes(a, e, order[i]);
        bt.b    = ref_lanes(b, e, order[i]);
        bt.odd  = (order[i] == 1);
        bt.last = (i == order.size() - 1);
        bt.err  = 1'b0;
        exp_q.push_back(bt);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({out_valid, opA, opB, out_odd, out_last, out_err, in_ready} !== {1'b1 == 1'b0, 32'd0, 32'd0, 3'b000, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got v=%0b a=%h b=%h o=%0b l=%0b e=%0b r=%0b want v=0 a=0 b=0 o=0 l=0 e=0 r=1",
               out_valid, opA, opB, out_odd, out_last, out_err, in_ready);
    end
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; op1 = 64'h0123456789abcdef; ww = 2'd0; mode = 2'd0;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_priority got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_single_beat();
    logic [63:0] b;
    b = {$urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b1; op1 = 64'h0011223344556677; op2 = b; ww = 2'd0; mode = 2'd0; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_in_ready got %0b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; op1 = 64'hffffffffffffffff;
    #1;
    total++;
    if ({out_valid, opA, opB, out_odd, out_last, out_err} !== {1'b1, 32'h00224466, ref_lanes(b, 8, 0), 3'b010}) begin
      bad++;
      $display("FAIL single_beat got v=%0b a=%h b=%h o=%0b l=%0b e=%0b want v=1 a=00224466 b=%h o=0 l=1 e=0",
               out_valid, opA, opB, out_odd, out_last, out_err, ref_lanes(b, 8, 0));
    end
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_two_beat();
    @(negedge clk);
    in_valid = 1'b1; op1 = 64'h0011223344556677; op2 = 64'h8899aabbccddeeff; ww = 2'd1; mode = 2'd2; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if ({opA, opB, out_odd, out_last, in_ready, out_valid} !== {32'h00114455, 32'h8899ccdd, 4'b0001}) begin
      bad++;
      $display("FAIL two_beat_first got a=%h b=%h o=%0b l=%0b r=%0b v=%0b want a=00114455 b=8899ccdd o=0 l=0 r=0 v=1",
               opA, opB, out_odd, out_last, in_ready, out_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if ({opA, opB, out_odd, out_last, out_err, in_ready} !== {32'h22336677, 32'haabbeeff, 4'b1101}) begin
      bad++;
      $display("FAIL two_beat_second got a=%h b=%h o=%0b l=%0b e=%0b r=%0b want a=22336677 b=aabbeeff o=1 l=1 e=0 r=1",
               opA, opB, out_odd, out_last, out_err, in_ready);
    end
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL two_beat_drain got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_illegal_ww();
    logic [127:0] wide;
    wide = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b1; op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom}; ww = 2'd3; mode = 2'd2; out_ready = 1'b1;
    w_in_valid = 1'b1; w_op1 = wide; w_op2 = ~wide; w_ww = 2'd3; w_mode = 2'd0; w_out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; w_in_valid = 1'b0;
    #1;
    total++;
    if ({out_valid, opA, opB, out_last, out_err} !== {1'b1, 32'd0, 32'd0, 2'b11}) begin
      bad++;
      $display("FAIL illegal_beat got v=%0b a=%h b=%h l=%0b e=%0b want v=1 a=0 b=0 l=1 e=1",
               out_valid, opA, opB, out_last, out_err);
    end
    total++;
    if ({w_out_valid, w_opA, w_opB, w_out_odd, w_out_last, w_out_err} !== {1'b1, wide[127:64], ~wide[127:64], 3'b010}) begin
      bad++;
      $display("FAIL wide_dword got v=%0b a=%h b=%h o=%0b l=%0b e=%0b want v=1 a=%h b=%h o=0 l=1 e=0",
               w_out_valid, w_opA, w_opB, w_out_odd, w_out_last, w_out_err, wide[127:64], ~wide[127:64]);
    end
    @(negedge clk);
    #1;
    total++;
    if ({out_valid, w_out_valid} !== 2'b00) begin
      bad++;
      $display("FAIL illegal_single got v=%0b wv=%0b want 0 0", out_valid, w_out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b1; op1 = a; op2 = b; ww = 2'd0; mode = 2'd3; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op1 = ~a; op2 = ~b; mode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) out_ready = 1'b1;
      #1;
      total++;
      if ({out_valid, opA, opB, out_odd, out_last, out_err, in_ready} !== {1'b1, ref_lanes(a, 8, 1), ref_lanes(b, 8, 1), 4'b1000}) begin
        bad++;
        $display("FAIL hold_odd[%0d] got v=%0b a=%h b=%h o=%0b l=%0b e=%0b r=%0b want v=1 a=%h b=%h o=1 l=0 e=0 r=0",
                 i, out_valid, opA, opB, out_odd, out_last, out_err, in_ready, ref_lanes(a, 8, 1), ref_lanes(b, 8, 1));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    total++;
    if ({out_valid, opA, opB, out_odd, out_last, out_err} !== {1'b1, ref_lanes(a, 8, 0), ref_lanes(b, 8, 0), 3'b010}) begin
      bad++;
      $display("FAIL hold_even_follow got v=%0b a=%h b=%h o=%0b l=%0b e=%0b want v=1 a=%h b=%h o=0 l=1 e=0",
               out_valid, opA, opB, out_odd, out_last, out_err, ref_lanes(a, 8, 0), ref_lanes(b, 8, 0));
    end
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_drain got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa, pb;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (i < 6);
      #1;
      if (i > 0) begin
        total++;
        if ({out_valid, in_ready, opA, opB, out_last} !== {1'b1, 1'b1, pa, pb, 1'b1}) begin
          bad++;
          $display("FAIL b2b[%0d] got v=%0b r=%0b a=%h b=%h l=%0b want v=1 r=1 a=%h b=%h l=1",
                   i, out_valid, in_ready, opA, opB, out_last, pa, pb);
        end
      end
      op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};
      ww = 2'($urandom_range(0, 2)); mode = 2'd0;
      pa = ref_lanes(op1, 8 << ww, 0);
      pb = ref_lanes(op2, 8 << ww, 0);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_beat2();
    @(negedge clk);
    in_valid = 1'b1; op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom}; ww = 2'd0; mode = 2'd2; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b0;
    #1;
    total++;
    if ({out_valid, out_odd, out_last} !== 3'b111) begin
      bad++;
      $display("FAIL mid_reset_in_beat2 got v=%0b o=%0b l=%0b want 1 1 1", out_valid, out_odd, out_last);
    end
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({out_valid, opA, out_last} !== {1'b0, 32'd0, 1'b0}) begin
        bad++;
        $display("FAIL mid_reset_discard[%0d] got v=%0b a=%h l=%0b want v=0 a=0 l=0", i, out_valid, opA, out_last);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    beat_t hd;
    logic  exp_rdy, exp_vld, acc, con;
    exp_q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op1  = {$urandom, $urandom};
      op2  = {$urandom, $urandom};
      ww   = 2'($urandom_range(0, 3));
      mode = 2'($urandom_range(0, 3));
      #1;
      exp_vld = (exp_q.size() != 0);
      exp_rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready);
      total++;
      if ({out_valid, in_ready} !== {exp_vld, exp_rdy}) begin
        bad++;
        $display("FAIL rand_handshake[%0d] got v=%0b r=%0b want v=%0b r=%0b", cyc, out_valid, in_ready, exp_vld, exp_rdy);
      end
      if (exp_vld) begin
        hd = exp_q[0];
        total++;
        if ({opA, opB, out_odd, out_last, out_err} !== {hd.a, hd.b, hd.odd, hd.last, hd.err}) begin
          bad++;
          $display("FAIL rand_beat[%0d] got a=%h b=%h o=%0b l=%0b e=%0b want a=%h b=%h o=%0b l=%0b e=%0b",
                   cyc, opA, opB, out_odd, out_last, out_err, hd.a, hd.b, hd.odd, hd.last, hd.err);
        end
      end
      acc = in_valid && exp_rdy;
      con = exp_vld && out_ready;
      @(posedge clk);
      if (con) void'(exp_q.pop_front());
      if (acc) push_request(op1, op2, ww, mode);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_two_beat();
    test_illegal_ww();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_beat2();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oe_lane_sequencer.md
OE_LANE_SEQUENCER -- requirements
Module: oe_lane_sequencer

Interface
REQ-001 Parameter DW, default 64, operand width in bits; power of two, minimum 16.
REQ-002 Parameter W_OUT, default DW/2, result width; fixed at DW/2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-007 op1, op2  input  [0:DW-1] each  operands, big-endian numbering, bit 0 is MSB.
REQ-008 ww  input  2  element width = 8<<ww bits (byte, half, word, dword).
REQ-009 mode  input  2  00 even only, 01 odd only, 10 even then odd, 11 odd then even.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  beat consumed when out_valid and out_ready are both high.
REQ-012 opA, opB  output  [0:W_OUT-1] each  packed selected lanes of op1 and op2.
REQ-013 out_odd  output  1  beat carries odd lanes.
REQ-014 out_last  output  1  final beat of the request.
REQ-015 out_err  output  1  request had an illegal ww.

Function
REQ-016 Element width E = 8<<ww; ww is legal iff 2*E <= DW; element k occupies bits [k*E : k*E+E-1].
REQ-017 Beat with parity p: output element j = operand element 2j+p, for j = 0 .. DW/(2E)-1, packed from bit 0.
REQ-018 op1, op2, ww and mode are registered on acceptance; later input changes do not affect an in-flight request.
REQ-019 Latency: request accepted in cycle N presents its first beat with out_valid=1 in cycle N+1.
REQ-020 FSM states: IDLE, BEAT1, BEAT2.
REQ-021 IDLE: on acceptance go to BEAT1.
REQ-022 BEAT1: on consumption with a two-beat mode go to BEAT2; with a one-beat mode go to IDLE, or back to BEAT1 if a new request is accepted in the same cycle.
REQ-023 BEAT2: on consumption go to IDLE, or to BEAT1 if a new request is accepted in the same cycle.
REQ-024 in_ready = (state==IDLE) | (out_valid & out_ready & out_last); a single-beat stream sustains one request per cycle.
REQ-025 Modes 00 and 01 give one beat with out_last=1. Mode 10 gives even then odd. Mode 11 gives odd then even. out_last=1 only on the second beat.
REQ-026 Backpressure: while out_valid=1 and out_ready=0, all outputs hold stable.
REQ-027 Illegal ww: the request is accepted and yields a single beat regardless of mode, with opA=opB=0, out_err=1 and out_last=1.
REQ-028 out_err=0 on every beat of a legal request.

Reset
REQ-029 reset forces state to IDLE, with out_valid=0, opA=opB=0, out_odd=0, out_last=0 and out_err=0; in_ready=1 in the cycle after reset.
REQ-030 Reset during BEAT1 or BEAT2 discards the in-flight request; no further beat of it appears.
REQ-031 reset has priority over a simultaneous acceptance.

Structure
REQ-032 A shared package holds the mode encodings, the ww encodings and the FSM state encoding.
REQ-033 One combinational sub-module, oe_lane_extract (parameter DW; inputs op, ww, odd; output res), performs the lane extraction; it is instantiated twice, once for op1 and once for op2.

Verification
REQ-034 DW=64, ww=00, mode=00, op1=0x0011223344556677 -> one cycle later opA=0x00224466, out_odd=0, out_last=1.
REQ-035 DW=64, ww=01, mode=10, op1=0x0011223344556677, out_ready=1 -> beat 1 opA=0x00114455 with out_odd=0; beat 2 opA=0x22336677 with out_odd=1 and out_last=1; in_ready=0 during beat 1.
REQ-036 DW=64, ww=11 -> one beat with opA=opB=0, out_err=1, out_last=1; DW=128, ww=11 -> opA = op1 bits [0:63], out_err=0.
REQ-037 mode=11 with out_ready held 0 for 3 cycles -> odd beat held stable throughout, then even beat follows with out_last=1.
REQ-038 Back-to-back mode=00 requests with out_ready=1 -> one beat per cycle, no bubbles.
REQ-039 reset asserted during BEAT2 of a mode=10 request -> out_valid=0 the next cycle; the pending beat never appears.
